panther_cluster_cfg_ctrl: RTL
=============================

Name: panther_cluster_cfg_ctrl

Overview:
- Runtime-programmable successor to the static cluster configuration set.
- Holds per-core boot addresses, a lockable control register and per-core fetch enables. Fetch enables are released in a staggered sequence under an FSM, and the block also generates software event pulses.
- Sits on the cluster peripheral interconnect as a slave (req/gnt, one-cycle response).
- Drives `boot_addr_o` and `fetch_en_o` of every core, and `evt_o` to the event unit.

Parameters:
- NB_CORES, 16, number of cores; legal values 4|8|16.
- BOOT_ADDR, 32'h1C000080, reset value of every per-core boot-address register.
- EVNT_WIDTH, 8, width of the software event output.
- STAGGER_CYCLES, 4, cycles between successive fetch-enable releases; 0 means release all at once.
- ADDR_WIDTH, 8, byte address width of the register port.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- req_i  in  1  access request.
- add_i  in  ADDR_WIDTH  byte address, word aligned.
- we_i  in  1  1 = write, 0 = read.
- wdata_i  in  32  write data.
- be_i  in  4  byte enables.
- gnt_o  out  1  grant.
- r_valid_o  out  1  response valid.
- r_rdata_o  out  32  read data.
- r_opc_o  out  1  1 = error response.
- boot_addr_o  out  NB_CORES*32  boot address per core; core i occupies bits [32i+31:32i].
- fetch_en_o  out  NB_CORES  per-core fetch enable.
- evt_o  out  EVNT_WIDTH  one-cycle software event pulses.

Behaviour:
- Reset values: every boot address = BOOT_ADDR; fetch_en_o = 0; FETCH_MASK = 0; LOCK = 0; evt_o = 0; r_valid_o = 0; r_opc_o = 0; r_rdata_o = 0; FSM in IDLE.
- Handshake:
  - gnt_o = req_i (combinational, always grant).
  - Exactly one response per granted access: r_valid_o = 1 in the next cycle, with r_rdata_o (reads) and r_opc_o.
  - Writes return r_rdata_o = 0.
  - Back-to-back requests are allowed every cycle.
- Register map:
  - 0x00 CTRL
    - bit0 LOCK: sticky, set by writing 1, cleared only by reset.
    - bit1 START: write-only, self-clearing.
    - bit2 BUSY: read-only, 1 in STAGGER.
    - bit3 STOP: write-only, self-clearing.
  - 0x04 FETCH_MASK [NB_CORES-1:0], read/write.
  - 0x08 FETCH_STATUS: read-only mirror of fetch_en_o.
  - 0x0C EVENT: write-only; bits [EVNT_WIDTH-1:0] are pulsed on evt_o in the cycle after the grant. Reads return 0.
  - 0x10 INFO: read-only; [7:0] = NB_CORES, [15:8] = EVNT_WIDTH, [23:16] = STAGGER_CYCLES.
  - 0x40 + 4*i, for i < NB_CORES: BOOT_ADDR[i], read/write.
- Byte enables apply to FETCH_MASK and BOOT_ADDR writes. CTRL and EVENT use only byte 0; a write with be_i[0] = 0 to them has no effect and no error.
- Error (r_opc_o = 1, no state change) on any of:
  - unmapped address;
  - write to FETCH_STATUS or INFO;
  - write to FETCH_MASK or BOOT_ADDR while LOCK = 1;
  - START while BUSY.
- Reads never error except on unmapped addresses.
- FSM IDLE:
  - Accepted START with FETCH_MASK != 0 latches the mask into a pending vector and enters STAGGER.
  - START with FETCH_MASK = 0 is a no-op with no error.
- FSM STAGGER:
  - The lowest-index pending core gets fetch_en set in the cycle after the START grant (cycle N+1).
  - Each subsequent pending core is set STAGGER_CYCLES cycles later. Unmasked indices are skipped without consuming cycles.
  - When the pending vector empties, return to IDLE; BUSY = 0 in the cycle the last core is released.
  - With STAGGER_CYCLES = 0, all masked cores are set at N+1 and the FSM never leaves IDLE (BUSY stays 0).
- fetch_en bits are sticky: they clear only on STOP or reset.
- STOP:
  - clears all fetch_en_o and the pending vector in cycle N+1;
  - aborts STAGGER and returns to IDLE;
  - allowed while locked.
  - START and STOP in the same write: STOP wins.
- Changing FETCH_MASK during STAGGER does not affect the latched sequence.
- Reset asserted mid-sequence returns the FSM to IDLE with every register at its reset value in the next cycle. No response is produced for a request granted in the reset cycle.
- Counters: the stagger counter is $clog2(STAGGER_CYCLES+1) bits and reloads after each release.

Test Plan:
- Reset, then read 0x10 -> rdata = 0x00040810 (defaults). Read 0x40 + 4*15 -> 0x1C000080.
- Write 0x40 = 0x1C001000 with be = 4'b0011 -> readback 0x1C001000; boot_addr_o[31:0] matches. Then write CTRL LOCK; write 0x40 -> r_opc_o = 1, value unchanged.
- FETCH_MASK = 0x8005, START at cycle N -> fetch_en_o bit0 set at N+1, bit2 at N+5, bit15 at N+9; BUSY reads 0 afterwards. A second START issued at N+2 -> r_opc_o = 1.
- Mask 0xFFFF, START, then STOP at N+6 -> at N+7 fetch_en_o = 0, FSM IDLE, bits 2..15 never set.
- Write EVENT = 0xA5 -> evt_o = 0xA5 for exactly one cycle after the grant, then 0. Access to 0x3C -> r_opc_o = 1. Back-to-back read/write/read sequence -> three consecutive valid responses.
- Assert rst_i during STAGGER after two releases -> next cycle: fetch_en_o = 0, BUSY = 0, FETCH_MASK = 0.

Source files
------------

// File: rtl/panther_cluster_cfg_ctrl.sv
// Cluster configuration controller: per-core boot addresses, lockable control,
// staggered fetch-enable release FSM and software event pulses on a req/gnt slave port.
module panther_cluster_cfg_ctrl #(
   parameter int          NB_CORES       = 16,
   parameter logic [31:0] BOOT_ADDR      = 32'h1C000080,
   parameter int          EVNT_WIDTH     = 8,
   parameter int          STAGGER_CYCLES = 4,
   parameter int          ADDR_WIDTH     = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     req_i,
   input  logic [ADDR_WIDTH-1:0]    add_i,
   input  logic                     we_i,
   input  logic [31:0]              wdata_i,
   input  logic [3:0]               be_i,
   output logic                     gnt_o,
   output logic                     r_valid_o,
   output logic [31:0]              r_rdata_o,
   output logic                     r_opc_o,
   output logic [NB_CORES*32-1:0]   boot_addr_o,
   output logic [NB_CORES-1:0]      fetch_en_o,
   output logic [EVNT_WIDTH-1:0]    evt_o
);

   localparam int IDX_W = $clog2(NB_CORES);
   localparam int CNT_W = (STAGGER_CYCLES > 0) ? $clog2(STAGGER_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_RELOAD = (STAGGER_CYCLES > 0) ? CNT_W'(STAGGER_CYCLES - 1) : '0;

   localparam logic [ADDR_WIDTH-3:0] W_CTRL     = 0;
   localparam logic [ADDR_WIDTH-3:0] W_MASK     = 1;
   localparam logic [ADDR_WIDTH-3:0] W_STATUS   = 2;
   localparam logic [ADDR_WIDTH-3:0] W_EVENT    = 3;
   localparam logic [ADDR_WIDTH-3:0] W_INFO     = 4;
   localparam logic [ADDR_WIDTH-3:0] W_BOOT     = 16;
   localparam logic [ADDR_WIDTH-3:0] W_BOOT_END = ADDR_WIDTH'(16 + NB_CORES) >> 0;

   typedef enum logic {IDLE, STAGGER} state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [NB_CORES-1:0]     pending_q, pending_d;
   logic [NB_CORES-1:0]     fetch_en_q, fetch_en_d;
   logic [NB_CORES-1:0]     fetch_mask_q;
   logic [31:0]             boot_addr_q [NB_CORES];
   logic                    lock_q;
   logic [EVNT_WIDTH-1:0]   evt_q;
   logic                    r_valid_q, r_opc_q;
   logic [31:0]             r_rdata_q, rdata_d;

   logic [ADDR_WIDTH-3:0]   word;
   logic [IDX_W-1:0]        boot_idx;
   logic is_ctrl, is_mask, is_status, is_event, is_info, is_boot, mapped;
   logic wr, rd, ctrl_wr, start_req, stop_req, busy, err, wr_ok;
   logic do_start, do_stop, lock_set;
   logic [NB_CORES-1:0]     low_mask, low_pend;
   logic                    unused_addr_lsb;

   function automatic logic [31:0] be_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                            input logic [3:0] be);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) res[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
      return res;
   endfunction

   assign word            = add_i[ADDR_WIDTH-1:2];
   assign unused_addr_lsb = ^add_i[1:0];
   assign boot_idx        = word[IDX_W-1:0];

   assign is_ctrl   = (word == W_CTRL);
   assign is_mask   = (word == W_MASK);
   assign is_status = (word == W_STATUS);
   assign is_event  = (word == W_EVENT);
   assign is_info   = (word == W_INFO);
   assign is_boot   = (word >= W_BOOT) && (word < W_BOOT_END);
   assign mapped    = is_ctrl | is_mask | is_status | is_event | is_info | is_boot;

   assign gnt_o     = req_i;
   assign wr        = req_i & we_i;
   assign rd        = req_i & ~we_i;
   assign busy      = (state_q == STAGGER);
   assign ctrl_wr   = wr & is_ctrl & be_i[0];
   assign start_req = ctrl_wr & wdata_i[1];
   assign stop_req  = ctrl_wr & wdata_i[3];

   // STOP takes precedence, so a START+STOP write while busy is not an error.
   assign err = req_i & (~mapped
                       | (we_i & (is_status | is_info))
                       | (we_i & lock_q & (is_mask | is_boot))
                       | (start_req & ~stop_req & busy));
   assign wr_ok    = wr & ~err;
   assign do_stop  = stop_req;
   assign do_start = start_req & ~stop_req & ~err;
   assign lock_set = ctrl_wr & wdata_i[0] & ~err;

   // Isolate the lowest set bit: that core is the next one released.
   assign low_mask = fetch_mask_q & (-fetch_mask_q);
   assign low_pend = pending_q & (-pending_q);

   always_comb begin
      rdata_d = '0;
      if (rd && !err) begin
         if (is_ctrl)   rdata_d = {29'd0, busy, 1'b0, lock_q};
         if (is_mask)   rdata_d = 32'(fetch_mask_q);
         if (is_status) rdata_d = 32'(fetch_en_q);
         if (is_info)   rdata_d = {8'd0, 8'(STAGGER_CYCLES), 8'(EVNT_WIDTH), 8'(NB_CORES)};
         if (is_boot)   rdata_d = boot_addr_q[boot_idx];
      end
   end

   // NOTE: every output of this block is defaulted first so no path leaves a latch.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pending_d  = pending_q;
      fetch_en_d = fetch_en_q;
      case (state_q)
         IDLE: begin
            if (do_start && fetch_mask_q != '0) begin
               if (STAGGER_CYCLES == 0) begin
                  fetch_en_d = fetch_en_q | fetch_mask_q;
               end else begin
                  fetch_en_d = fetch_en_q | low_mask;
                  pending_d  = fetch_mask_q & ~low_mask;
                  cnt_d      = CNT_RELOAD;
                  if ((fetch_mask_q & ~low_mask) != '0) state_d = STAGGER;
               end
            end
         end
         STAGGER: begin
            if (cnt_q == '0) begin
               fetch_en_d = fetch_en_q | low_pend;
               pending_d  = pending_q & ~low_pend;
               cnt_d      = CNT_RELOAD;
               if ((pending_q & ~low_pend) == '0) state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (do_stop) begin
         state_d    = IDLE;
         cnt_d      = '0;
         pending_d  = '0;
         fetch_en_d = '0;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         pending_q    <= '0;
         fetch_en_q   <= '0;
         fetch_mask_q <= '0;
         lock_q       <= 1'b0;
         evt_q        <= '0;
         r_valid_q    <= 1'b0;
         r_opc_q      <= 1'b0;
         r_rdata_q    <= '0;
         // NOTE: the boot-address array is deliberately reset; cores boot from it after reset.
         for (int i = 0; i < NB_CORES; i++) boot_addr_q[i] <= BOOT_ADDR;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pending_q  <= pending_d;
         fetch_en_q <= fetch_en_d;
         if (lock_set) lock_q <= 1'b1;
         if (wr_ok && is_mask)
            fetch_mask_q <= NB_CORES'(be_merge(32'(fetch_mask_q), wdata_i, be_i));
         if (wr_ok && is_boot)
            boot_addr_q[boot_idx] <= be_merge(boot_addr_q[boot_idx], wdata_i, be_i);
         evt_q     <= (wr_ok && is_event && be_i[0]) ? wdata_i[EVNT_WIDTH-1:0] : '0;
         r_valid_q <= req_i;
         r_opc_q   <= err;
         r_rdata_q <= rdata_d;
      end
   end

   for (genvar g = 0; g < NB_CORES; g++) begin : g_boot
      assign boot_addr_o[32*g +: 32] = boot_addr_q[g];
   end

   assign fetch_en_o = fetch_en_q;
   assign evt_o      = evt_q;
   assign r_valid_o  = r_valid_q;
   assign r_opc_o    = r_opc_q;
   assign r_rdata_o  = r_rdata_q;

endmodule
